reg_wb_arb: RTL and testbench
=============================

REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 SHALL be exactly: one clock; reset is synchronous and active-high.
REQ-002 Port list, in order:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- hold  in  1  suspend new grants (pipeline stall)
- ex_valid  in  1  execute-stage writeback request
- ex_addr  in  reg_addr_t  execute destination register
- ex_data  in  core_word_t  execute writeback data
- ex_ready  out  1  execute request accepted this cycle
- mem_valid  in  1  memory-stage writeback request
- mem_addr  in  reg_addr_t  memory destination register
- mem_data  in  core_word_t  memory writeback data
- mem_ready  out  1  memory request accepted this cycle
- w  out  1  register-file write enable
- dr_addr  out  reg_addr_t  register-file destination address
- d_in  out  core_word_t  register-file write data
REQ-003 Parameters: none; width taken from attrs (reg_addr_t, core_word_t, N_REGS).

Function
REQ-004 Transfer: a request is accepted in a cycle where its valid and ready are both high; ready is combinational from valid, hold and priority state.
REQ-005 hold high: ex_ready = mem_ready = 0; no new acceptance.
REQ-006 ready is never high while the corresponding valid is low; at most one ready is high per cycle.
REQ-007 Single valid requester with hold low: that requester is granted.
REQ-008 Both valid, hold low: round-robin; grant the requester not granted most recently (prio bit).
REQ-009 prio bit updates on every acceptance to the granted requester, including dropped writes.
REQ-010 Accepted write loads pending register {pend, pend_addr, pend_data}; w = pend, dr_addr = pend_addr, d_in = pend_data; latency accept-to-w exactly 1 cycle.
REQ-011 pend clears the cycle after it is set unless a new acceptance reloads it; back-to-back accepts give w high on consecutive cycles.
REQ-012 hold does not stall a pending write already registered; it drains on schedule.
REQ-013 Accepted write to address 0 (zero register) or N_REGS-1 (core ID) SHALL be dropped: ready still high, pend not set, w low next cycle.
REQ-014 Both requesters targeting the same address: handled as ordinary contention; writes land in grant order, no merging.
REQ-015 dr_addr/d_in hold their last loaded value while w is low.

Reset
REQ-016 rst high: pend = 0, w = 0, dr_addr = 0, d_in = 0, ex_ready = mem_ready = 0, prio favours ex for the first tie.
REQ-017 rst asserted with a pending write: write discarded, w low the cycle after reset; rst overrides hold and valid.

Configuration
REQ-018 Macro WB_FWD_EN defined: extra ports sr1addr, sr2addr (in, reg_addr_t), fwd1_hit, fwd2_hit (out, 1), fwd_data (out, core_word_t).
REQ-019 With WB_FWD_EN: fwdN_hit = pend && srNaddr == pend_addr, combinational; fwd_data = pend_data; dropped writes never hit; hits 0 in reset.
REQ-020 Without WB_FWD_EN: forwarding ports and logic absent; all other behaviour identical.

Verification
REQ-021 Reset: rst high 2 cycles with ex_valid=1 -> w=0, both ready=0, d_in=0 throughout and the cycle after.
REQ-022 Single write: ex_valid=1, ex_addr=5, ex_data=0xDEADBEEF -> ex_ready=1 same cycle; next cycle w=1, dr_addr=5, d_in=0xDEADBEEF.
REQ-023 Contention: both valid 4 cycles (ex addr 3, mem addr 14) -> grants ex, mem, ex, mem; w high 4 consecutive cycles, addresses 3,14,3,14.
REQ-024 Drop: mem_valid=1, mem_addr=15 then mem_addr=0 -> mem_ready=1 both cycles, w=0 both following cycles.
REQ-025 Hold: hold=1 for 3 cycles, ex_valid=1 -> ex_ready=0, w=0; hold drops -> accept, w one cycle later; a write registered before hold still drains.
REQ-026 WB_FWD_EN: accept ex_addr=7, data=0x12345678, sr1addr=7, sr2addr=8 next cycle -> fwd1_hit=1, fwd2_hit=0, fwd_data=0x12345678.

Source files
------------

// File: rtl/reg_wb_arb.sv
// Two-source register-file writeback arbiter: execute and memory stages share one write port.
// Optional forwarding from the pending write is enabled by defining WB_FWD_EN.
module reg_wb_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        ex_valid,
    input  logic [3:0]  ex_addr,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        w,
    output logic [3:0]  dr_addr,
    output logic [31:0] d_in
`ifdef WB_FWD_EN
    ,
    input  logic [3:0]  sr1addr,
    input  logic [3:0]  sr2addr,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd_data
`endif
);
    localparam int          N_REGS  = 16;
    localparam logic [3:0]  ZERO_REG = 4'd0;
    localparam logic [3:0]  CORE_ID  = 4'(N_REGS - 1);

    // prio_q high: execute wins the next tie (memory was granted most recently)
    logic        prio_q, prio_d;
    logic        pend_q, pend_d;
    logic [3:0]  pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;

    logic        accept;
    logic [3:0]  sel_addr;
    logic [31:0] sel_data;
    logic        drop;

    always_comb begin
        ex_ready  = ~rst & ~hold & ex_valid  & (~mem_valid | prio_q);
        mem_ready = ~rst & ~hold & mem_valid & (~ex_valid  | ~prio_q);
        accept    = ex_ready | mem_ready;
        sel_addr  = ex_ready ? ex_addr : mem_addr;
        sel_data  = ex_ready ? ex_data : mem_data;
        drop      = (sel_addr == ZERO_REG) || (sel_addr == CORE_ID);

        prio_d      = prio_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (accept) begin
            prio_d = mem_ready;
            if (!drop) begin
                pend_d      = 1'b1;
                pend_addr_d = sel_addr;
                pend_data_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b1;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            prio_q      <= prio_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Reset masks the write port immediately so a pending write never lands during reset
    assign w       = pend_q & ~rst;
    assign dr_addr = rst ? 4'd0  : pend_addr_q;
    assign d_in    = rst ? 32'd0 : pend_data_q;

`ifdef WB_FWD_EN
    assign fwd1_hit = w && (sr1addr == pend_addr_q);
    assign fwd2_hit = w && (sr2addr == pend_addr_q);
    assign fwd_data = d_in;
`endif

endmodule

// File: tb/tb_reg_wb_arb.sv
// Table-driven bench for reg_wb_arb with a scoreboard of expected write-port values.
module tb_reg_wb_arb;
    logic        clk = 1'b0;
    logic        rst, hold, ex_valid, mem_valid;
    logic [3:0]  ex_addr, mem_addr;
    logic [31:0] ex_data, mem_data;
    logic        ex_ready, mem_ready, w;
    logic [3:0]  dr_addr;
    logic [31:0] d_in;
`ifdef WB_FWD_EN
    logic [3:0]  sr1addr = 4'd0, sr2addr = 4'd0;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    reg_wb_arb dut (
        .clk(clk), .rst(rst), .hold(hold),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .w(w), .dr_addr(dr_addr), .d_in(d_in)
`ifdef WB_FWD_EN
        , .sr1addr(sr1addr), .sr2addr(sr2addr),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
`endif
    );

    typedef struct {
        logic        rst, hold;
        logic        exv;  logic [3:0] exa;  logic [31:0] exd;
        logic        memv; logic [3:0] mema; logic [31:0] memd;
        logic        er, mr;
    } vec_t;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } out_t;

    out_t        sb[$];
    logic [3:0]  last_a = 4'd0;
    logic [31:0] last_d = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic h,
                                input logic ev, input logic [3:0] ea, input logic [31:0] ed,
                                input logic mv, input logic [3:0] ma, input logic [31:0] md,
                                input logic er, input logic mr);
        vec_t v;
        v.rst = r; v.hold = h;
        v.exv = ev; v.exa = ea; v.exd = ed;
        v.memv = mv; v.mema = ma; v.memd = md;
        v.er = er; v.mr = mr;
        return v;
    endfunction

    // One cycle: drive after the edge, check at the falling edge, then push next-cycle expectation
    task automatic step(input vec_t v);
        out_t e, n;
        logic [3:0] a;
        @(posedge clk); #1;
        rst = v.rst; hold = v.hold;
        ex_valid = v.exv;   ex_addr = v.exa;   ex_data = v.exd;
        mem_valid = v.memv; mem_addr = v.mema; mem_data = v.memd;
        @(negedge clk);
        cyc++;
        chk("ex_ready", 32'(ex_ready), 32'(v.er));
        chk("mem_ready", 32'(mem_ready), 32'(v.mr));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (v.rst) begin
                e.w = 1'b0; e.a = 4'd0; e.d = 32'd0;
            end
            chk("w", 32'(w), 32'(e.w));
            chk("dr_addr", 32'(dr_addr), 32'(e.a));
            chk("d_in", d_in, e.d);
        end
        $display("cyc %0d rst=%0b hold=%0b exv=%0b memv=%0b | ex_ready=%0b mem_ready=%0b w=%0b dr_addr=%0d d_in=%h",
                 cyc, v.rst, v.hold, v.exv, v.memv, ex_ready, mem_ready, w, dr_addr, d_in);
        if (v.rst) begin
            last_a = 4'd0; last_d = 32'd0;
            n.w = 1'b0;
        end else if (v.er || v.mr) begin
            a = v.er ? v.exa : v.mema;
            if (a == 4'd0 || a == 4'd15) begin
                n.w = 1'b0;
            end else begin
                n.w = 1'b1;
                last_a = a;
                last_d = v.er ? v.exd : v.memd;
            end
        end else begin
            n.w = 1'b0;
        end
        n.a = last_a; n.d = last_d;
        sb.push_back(n);
    endtask

    vec_t tbl[25];

    initial begin
        rst = 1'b0; hold = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0;
        ex_addr = '0; mem_addr = '0; ex_data = '0; mem_data = '0;

        //             rst hold exv ea    ed            memv ma     md           er mr
        tbl[0]  = mk(1, 0, 1, 4'd5,  32'h1111_1111, 0, 4'd0,  32'h0,        0, 0);
        tbl[1]  = mk(1, 0, 1, 4'd5,  32'h1111_1111, 0, 4'd0,  32'h0,        0, 0);
        tbl[2]  = mk(0, 0, 1, 4'd3,  32'hA000_0001, 1, 4'd14, 32'hB000_0001, 1, 0);
        tbl[3]  = mk(0, 0, 1, 4'd3,  32'hA000_0002, 1, 4'd14, 32'hB000_0002, 0, 1);
        tbl[4]  = mk(0, 0, 1, 4'd3,  32'hA000_0003, 1, 4'd14, 32'hB000_0003, 1, 0);
        tbl[5]  = mk(0, 0, 1, 4'd3,  32'hA000_0004, 1, 4'd14, 32'hB000_0004, 0, 1);
        tbl[6]  = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);
        tbl[7]  = mk(0, 0, 1, 4'd5,  32'hDEAD_BEEF, 0, 4'd0,  32'h0,        1, 0);
        tbl[8]  = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);
        tbl[9]  = mk(0, 0, 0, 4'd0,  32'h0,         1, 4'd15, 32'hCAFE_0015, 0, 1);
        tbl[10] = mk(0, 0, 0, 4'd0,  32'h0,         1, 4'd0,  32'hCAFE_0000, 0, 1);
        tbl[11] = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);
        tbl[12] = mk(0, 0, 1, 4'd9,  32'h0000_0099, 0, 4'd0,  32'h0,        1, 0);
        tbl[13] = mk(0, 1, 1, 4'd10, 32'h0000_00AA, 0, 4'd0,  32'h0,        0, 0);
        tbl[14] = mk(0, 1, 1, 4'd10, 32'h0000_00AA, 1, 4'd2,  32'h22,       0, 0);
        tbl[15] = mk(0, 1, 1, 4'd10, 32'h0000_00AA, 0, 4'd0,  32'h0,        0, 0);
        tbl[16] = mk(0, 0, 1, 4'd10, 32'h0000_00AA, 0, 4'd0,  32'h0,        1, 0);
        tbl[17] = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);
        tbl[18] = mk(0, 0, 1, 4'd6,  32'h0000_0061, 1, 4'd6,  32'h0000_0062, 0, 1);
        tbl[19] = mk(0, 0, 1, 4'd6,  32'h0000_0061, 1, 4'd6,  32'h0000_0063, 1, 0);
        tbl[20] = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);
        tbl[21] = mk(0, 0, 0, 4'd0,  32'h0,         1, 4'd12, 32'h0000_0C0C, 0, 1);
        tbl[22] = mk(0, 0, 1, 4'd4,  32'h0000_0044, 0, 4'd0,  32'h0,        1, 0);
        tbl[23] = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);
        tbl[24] = mk(0, 0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,        0, 0);

        for (int i = 0; i < 25; i++) step(tbl[i]);

        // Reset arriving with a write pending, hold and valid all asserted
        step(mk(0, 0, 1, 4'd8, 32'h0000_0088, 0, 4'd0, 32'h0, 1, 0));
        step(mk(1, 1, 1, 4'd9, 32'h0000_0099, 1, 4'd9, 32'h9, 0, 0));
        step(mk(0, 0, 0, 4'd0, 32'h0,         0, 4'd0, 32'h0, 0, 0));
        // First tie after reset goes to execute
        step(mk(0, 0, 1, 4'd1, 32'h0000_0101, 1, 4'd2, 32'h0000_0202, 1, 0));
        step(mk(0, 0, 0, 4'd0, 32'h0,         0, 4'd0, 32'h0,         0, 0));

`ifdef WB_FWD_EN
        step(mk(0, 0, 1, 4'd7, 32'h1234_5678, 0, 4'd0, 32'h0, 1, 0));
        sr1addr = 4'd7; sr2addr = 4'd8;
        step(mk(0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0));
        chk("fwd1_hit", 32'(fwd1_hit), 32'd1);
        chk("fwd2_hit", 32'(fwd2_hit), 32'd0);
        chk("fwd_data", fwd_data, 32'h1234_5678);
        step(mk(0, 0, 0, 4'd0, 32'h0, 1, 4'd15, 32'h5555_5555, 0, 1));
        sr1addr = 4'd15;
        step(mk(0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0));
        chk("fwd1_hit_drop", 32'(fwd1_hit), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
